// File: rtl/sc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sc_ctrl_pkg
// Description : Shared types, default widths and helpers for the
//               switched-capacitor clock controllers.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents
//   CNT_W_DEF   default width of phase-length / dead-time fields
//   CYC_W_DEF   default width of the completed-cycle counter
//   sc_phase_e  phase-sequencer state encoding
//   eff_len()   maps a zero length to one, leaves all other lengths alone
// ============================================================================
package sc_ctrl_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int CYC_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      D12  = 3'd2,
      P2   = 3'd3,
      D21  = 3'd4
   } sc_phase_e;

   // Operates on a 32-bit container so controllers of any field width up to
   // 32 bits can share it; callers size the result back to their own width.
   function automatic logic [31:0] eff_len(input logic [31:0] x);
      return (x == 32'd0) ? 32'd1 : x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : sc_phase_timer
// Description : Loadable down-counter that times one sequencer state.
//               The count sticks at 1 once reached; done is high while the
//               count equals 1, i.e. in the last cycle of the timed state.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      synchronous reset, active-low
//   load_i       in   1      load load_val_i at the next edge
//   load_val_i   in   CNT_W  value to load (expected >= 1)
//   cnt_nxt_o    out  CNT_W  counter value after the next edge
//   done_o       out  1      counter currently equals 1
// ============================================================================
module sc_phase_timer
   import sc_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_nxt_o,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q > CNT_W'(1)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The next value is exported so the owner can decode registered outputs
   // that line up with the counter it will hold in the following cycle.
   assign cnt_nxt_o = cnt_d;
   assign done_o    = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/sc_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sc_phase_sequencer
// Description : Non-overlapping two-phase clock generator for a
//               switched-capacitor filter. Produces phi1/phi2, their
//               early-falling bottom-plate variants phi1e/phi2e, a sample
//               strobe per completed integrate cycle and a cycle counter.
//               Phase lengths, dead time and early-fall amount are
//               programmable and snapshotted at every cycle start.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      synchronous reset, active-low
//   en           in   1      run request, level sensitive
//   cfg_p1_len   in   CNT_W  phi1 high time (0 behaves as 1)
//   cfg_p2_len   in   CNT_W  phi2 high time (0 behaves as 1)
//   cfg_dead     in   CNT_W  non-overlap gap (0 behaves as 1)
//   cfg_early    in   CNT_W  cycles by which phiNe falls before phiN
//   phi1         out  1      sample phase
//   phi2         out  1      integrate phase
//   phi1e        out  1      early-falling phi1
//   phi2e        out  1      early-falling phi2
//   sample_strb  out  1      pulse in the first cycle after phi2 falls
//   busy         out  1      sequencer not idle
//   cycle_cnt    out  CYC_W  completed phi1+phi2 cycles, wrapping
// ============================================================================
module sc_phase_sequencer
   import sc_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int CYC_W = CYC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] cfg_p1_len,
   input  logic [CNT_W-1:0] cfg_p2_len,
   input  logic [CNT_W-1:0] cfg_dead,
   input  logic [CNT_W-1:0] cfg_early,
   output logic             phi1,
   output logic             phi2,
   output logic             phi1e,
   output logic             phi2e,
   output logic             sample_strb,
   output logic             busy,
   output logic [CYC_W-1:0] cycle_cnt
);

   // eff_early = min(early, len-1); len is already clamped to >= 1 here.
   function automatic logic [CNT_W-1:0] clamp_early(input logic [CNT_W-1:0] early,
                                                    input logic [CNT_W-1:0] len);
      return (early > (len - CNT_W'(1))) ? (len - CNT_W'(1)) : early;
   endfunction

   // ------------------------------------------------------------------------
   // State and snapshot registers
   // ------------------------------------------------------------------------
   sc_phase_e        state_q, state_d;
   logic [CNT_W-1:0] p2_len_q, p2_len_d;
   logic [CNT_W-1:0] dead_q, dead_d;
   logic [CNT_W-1:0] early1_q, early1_d;
   logic [CNT_W-1:0] early2_q, early2_d;

   logic             phi1_q, phi2_q, phi1e_q, phi2e_q;
   logic             strb_q, busy_q;
   logic [CYC_W-1:0] cycle_cnt_q;

   // Clamped view of the live configuration inputs
   logic [CNT_W-1:0] p1_len_in, p2_len_in, dead_in;

   logic             snap;
   logic             cycle_done;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic [CNT_W-1:0] tmr_cnt_nxt;
   logic             tmr_done;

   always_comb begin
      p1_len_in = CNT_W'(eff_len(32'(cfg_p1_len)));
      p2_len_in = CNT_W'(eff_len(32'(cfg_p2_len)));
      dead_in   = CNT_W'(eff_len(32'(cfg_dead)));
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Every state waits for the timer to reach 1; only the
   // exit from D21 consults en, so dropping en never shortens a phase.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (en)       state_d = P1;
         P1:   if (tmr_done) state_d = D12;
         D12:  if (tmr_done) state_d = P2;
         P2:   if (tmr_done) state_d = D21;
         D21:  if (tmr_done) state_d = en ? P1 : IDLE;
         default:            state_d = IDLE;
      endcase
   end

   // P1 is only ever entered from IDLE or D21, so entering P1 is exactly the
   // cycle boundary at which the configuration is captured.
   assign snap       = (state_d == P1) && (state_q != P1);
   assign cycle_done = (state_q == P2) && (state_d == D21);

   always_comb begin
      p2_len_d = snap ? p2_len_in                             : p2_len_q;
      dead_d   = snap ? dead_in                               : dead_q;
      early1_d = snap ? clamp_early(cfg_early, p1_len_in)     : early1_q;
      early2_d = snap ? clamp_early(cfg_early, p2_len_in)     : early2_q;
   end

   // ------------------------------------------------------------------------
   // Timer reload on every state entry. P1 takes its length straight from
   // the inputs because its load coincides with the snapshot edge; later
   // states read the snapshot registers, which are settled by then.
   // ------------------------------------------------------------------------
   always_comb begin
      tmr_load     = (state_d != state_q) && (state_d != IDLE);
      tmr_load_val = '0;
      case (state_d)
         P1:       tmr_load_val = p1_len_in;
         D12, D21: tmr_load_val = dead_q;
         P2:       tmr_load_val = p2_len_q;
         default:  tmr_load_val = '0;
      endcase
   end

   sc_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .cnt_nxt_o  (tmr_cnt_nxt),
      .done_o     (tmr_done)
   );

   // ------------------------------------------------------------------------
   // FSM registers and registered output decode. Outputs are decoded from
   // the next state so each phi changes on the same edge as the state, with
   // no combinational path from any input to a switch gate.
   // The timer's next value counts down len..1 across a phase; phiNe stays
   // high while that count exceeds eff_early, i.e. for len-eff_early cycles.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         p2_len_q    <= '0;
         dead_q      <= '0;
         early1_q    <= '0;
         early2_q    <= '0;
         phi1_q      <= 1'b0;
         phi2_q      <= 1'b0;
         phi1e_q     <= 1'b0;
         phi2e_q     <= 1'b0;
         strb_q      <= 1'b0;
         busy_q      <= 1'b0;
         cycle_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         p2_len_q <= p2_len_d;
         dead_q   <= dead_d;
         early1_q <= early1_d;
         early2_q <= early2_d;

         phi1_q   <= (state_d == P1);
         phi2_q   <= (state_d == P2);
         phi1e_q  <= (state_d == P1) && (tmr_cnt_nxt > early1_d);
         phi2e_q  <= (state_d == P2) && (tmr_cnt_nxt > early2_d);
         strb_q   <= cycle_done;
         busy_q   <= (state_d != IDLE);

         if (cycle_done) begin
            cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
         end
      end
   end

   assign phi1        = phi1_q;
   assign phi2        = phi2_q;
   assign phi1e       = phi1e_q;
   assign phi2e       = phi2e_q;
   assign sample_strb = strb_q;
   assign busy        = busy_q;
   assign cycle_cnt   = cycle_cnt_q;

endmodule
`default_nettype wire
